// File: rtl/axi_dma_rd.sv
// AXI4 read master (MM2S): streams a DDR buffer out over AXI4-Stream in fixed
// INCR bursts, with optional continuous looping over the buffer.
module axi_dma_rd #(
   parameter int         BURST_LEN = 16,
   parameter int         MAX_OUTST = 4,
   parameter logic [3:0] ARID      = 4'd0
) (
   input  logic         axi_aclk,
   input  logic         axi_rstb,
   output logic [31:0]  axi_araddr,
   output logic [7:0]   axi_arlen,
   output logic [2:0]   axi_arsize,
   output logic [1:0]   axi_arburst,
   output logic [3:0]   axi_arcache,
   output logic [2:0]   axi_arprot,
   output logic [3:0]   axi_arid,
   output logic [3:0]   axi_aruser,
   output logic         axi_arvalid,
   input  logic         axi_arready,
   input  logic [255:0] axi_rdata,
   input  logic [1:0]   axi_rresp,
   input  logic         axi_rlast,
   input  logic         axi_rvalid,
   output logic         axi_rready,
   output logic [255:0] axis_tdata,
   output logic [31:0]  axis_tkeep,
   output logic         axis_tlast,
   output logic         axis_tvalid,
   input  logic         axis_tready,
   input  logic         read_start,
   input  logic         read_reset,
   input  logic         loop_en,
   input  logic [31:0]  start_address,
   input  logic [31:0]  read_size,
   output logic [31:0]  current_addr,
   output logic [7:0]   run_cycles,
   output logic         rd_err,
   output logic         rd_done,
   output logic         busy
);
   localparam logic [3:0]  MAX_O   = 4'(MAX_OUTST);
   localparam logic [31:0] BURST_B = 32'(BURST_LEN * 32);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ABORT} state_t;
   state_t state, state_nx;

   logic        start_d, ar_hold;
   logic [31:0] base, addr;
   logic [22:0] nburst, issued;
   logic [3:0]  outst;
   logic [27:0] beat_cnt, beat_last;
   logic        start_ok, active, ar_hs, r_hs, beat_hs, last_burst;
   logic        unused_ok;

   assign unused_ok  = ^{start_address[8:0], read_size[8:0]};
   assign start_ok   = read_start & ~start_d & (read_size[31:9] != 23'd0);
   assign active     = (state == ISSUE) || (state == DRAIN);
   assign ar_hs      = axi_arvalid & axi_arready;
   assign r_hs       = axi_rvalid & axi_rready;
   assign beat_hs    = active & r_hs;
   assign last_burst = (issued + 23'd1) == nburst;
   assign beat_last  = 28'(nburst) * 28'(BURST_LEN) - 28'd1;

   assign axi_araddr  = addr;
   assign axi_arlen   = 8'(BURST_LEN - 1);
   assign axi_arsize  = 3'b101;
   assign axi_arburst = 2'b01;
   assign axi_arcache = 4'b0011;
   assign axi_arprot  = 3'd0;
   assign axi_arid    = ARID;
   assign axi_aruser  = 4'd0;
   // In ABORT only an AR already presented is kept up until it is taken.
   assign axi_arvalid = ((state == ISSUE) && (outst < MAX_O)) || ((state == ABORT) && ar_hold);

   assign axi_rready  = active ? axis_tready : (state == ABORT);
   assign axis_tvalid = active & axi_rvalid;
   assign axis_tdata  = active ? axi_rdata : '0;
   assign axis_tkeep  = active ? '1 : '0;
   assign axis_tlast  = active && (beat_cnt == beat_last);
   assign busy        = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_ok) state_nx = ISSUE;
         ISSUE: if (read_reset) state_nx = ABORT;
                else if (ar_hs && last_burst && !loop_en) state_nx = DRAIN;
         DRAIN: if (read_reset) state_nx = ABORT;
                else if (outst == 4'd0) state_nx = IDLE;
         ABORT: if ((outst == 4'd0) && !axi_arvalid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_rstb) begin
      if (!axi_rstb) begin
         state        <= IDLE;
         start_d      <= 1'b0;
         ar_hold      <= 1'b0;
         base         <= '0;
         addr         <= '0;
         nburst       <= '0;
         issued       <= '0;
         outst        <= '0;
         beat_cnt     <= '0;
         current_addr <= '0;
         run_cycles   <= '0;
         rd_err       <= 1'b0;
         rd_done      <= 1'b0;
      end else begin
         state   <= state_nx;
         start_d <= read_start;
         ar_hold <= axi_arvalid & ~axi_arready;
         rd_done <= (state == DRAIN) && (state_nx == IDLE);
         if ((state == IDLE) && start_ok) begin
            base       <= {start_address[31:9], 9'b0};
            addr       <= {start_address[31:9], 9'b0};
            nburst     <= read_size[31:9];
            issued     <= '0;
            beat_cnt   <= '0;
            run_cycles <= '0;
            rd_err     <= 1'b0;
         end
         if (ar_hs) begin
            current_addr <= axi_araddr;
            if (state == ISSUE) begin
               if (last_burst && loop_en) begin
                  addr   <= base;
                  issued <= '0;
               end else begin
                  addr   <= addr + BURST_B;
                  issued <= issued + 23'd1;
               end
            end
         end
         case ({ar_hs, r_hs & axi_rlast})
            2'b10:   outst <= outst + 4'd1;
            2'b01:   outst <= outst - 4'd1;
            default: ;
         endcase
         if (beat_hs) begin
            if (axis_tlast) begin
               beat_cnt   <= '0;
               run_cycles <= run_cycles + 8'd1;
            end else begin
               beat_cnt <= beat_cnt + 28'd1;
            end
            if (axi_rresp != 2'b00) rd_err <= 1'b1;
         end
         // Abort (or an explicit reset request) wipes the run status.
         if (read_reset || (state == ABORT)) begin
            run_cycles <= '0;
            rd_err     <= 1'b0;
         end
      end
   end
endmodule
